// File: rtl/d_flop.sv
// Parameterisable capture pipeline with registered edge flags and a transition counter.
// Optional clock enable input is compiled in when D_FLOP_CE_EN is defined.
module d_flop #(
  parameter int                 WIDTH     = 1,
  parameter int                 STAGES    = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
  parameter int                 CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef D_FLOP_CE_EN
  input  logic             ce,
`endif
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_rise,
  output logic             q_fall,
  output logic             q_chg,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];
  logic             rise_q, fall_q, chg_q;
  logic             rise_d, fall_d, chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_s;

`ifdef D_FLOP_CE_EN
  assign en_s = ce;
`else
  assign en_s = 1'b1;
`endif

  // Next-state: shift the pipeline and derive flags from new q versus the current q
  // (the current last stage is the prior-cycle value of q).
  always_comb begin
    stage_d = stage_q;
    if (en_s) begin
      stage_d[0] = d;
      for (int i = 1; i < STAGES; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end else begin
      stage_d = stage_q;
    end
    chg_d  = en_s & (stage_d[STAGES-1] != stage_q[STAGES-1]);
    rise_d = en_s & stage_d[STAGES-1][0] & ~stage_q[STAGES-1][0];
    fall_d = en_s & ~stage_d[STAGES-1][0] & stage_q[STAGES-1][0];
    if (chg_d) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset discards every in-flight stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= RESET_VAL;
      end
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      chg_q  <= 1'b0;
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      stage_q <= stage_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      chg_q   <= chg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q       = stage_q[STAGES-1];
  assign q_rise  = rise_q;
  assign q_fall  = fall_q;
  assign q_chg   = chg_q;
  assign chg_cnt = cnt_q;

endmodule

// File: tb/tb_d_flop.sv
// Directed, table-driven bench for d_flop: three instances cover the
// default build, a 3-stage 8-bit pipe and a 4-bit counter wrap.
module tb_d_flop;

  logic clk = 1'b0;
  logic rst;
`ifdef D_FLOP_CE_EN
  logic ce;
`endif
  logic       d1, q1, r1, f1, c1;
  logic [15:0] n1;
  logic [7:0] d3, q3;
  logic       r3, f3, c3;
  logic [15:0] n3;
  logic       d4, q4, r4, f4, c4;
  logic [3:0] n4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  d_flop u1 (
    .clk(clk), .rst(rst),
`ifdef D_FLOP_CE_EN
    .ce(ce),
`endif
    .d(d1), .q(q1), .q_rise(r1), .q_fall(f1), .q_chg(c1), .chg_cnt(n1));

  d_flop #(.WIDTH(8), .STAGES(3)) u3 (
    .clk(clk), .rst(rst),
`ifdef D_FLOP_CE_EN
    .ce(ce),
`endif
    .d(d3), .q(q3), .q_rise(r3), .q_fall(f3), .q_chg(c3), .chg_cnt(n3));

  d_flop #(.CNT_W(4)) u4 (
    .clk(clk), .rst(rst),
`ifdef D_FLOP_CE_EN
    .ce(ce),
`endif
    .d(d4), .q(q4), .q_rise(r4), .q_fall(f4), .q_chg(c4), .chg_cnt(n4));

  typedef struct {
    logic d;
    logic q;
    logic rise;
    logic fall;
    logic chg;
    int   cnt;
  } vec_t;

  vec_t tbl [9];
  logic [7:0] lat_q   [5] = '{8'h00, 8'h00, 8'hA5, 8'h00, 8'h00};
  logic       lat_chg [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  int         lat_cnt [5] = '{0, 0, 1, 2, 2};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_u1(input string nm, input logic q, input logic r, input logic f,
                        input logic c, input int n);
    chk({nm, ".q"},    {31'd0, q1}, {31'd0, q});
    chk({nm, ".rise"}, {31'd0, r1}, {31'd0, r});
    chk({nm, ".fall"}, {31'd0, f1}, {31'd0, f});
    chk({nm, ".chg"},  {31'd0, c1}, {31'd0, c});
    chk({nm, ".cnt"},  {16'd0, n1}, n);
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7};

    rst = 1'b1; d1 = 1'b1; d3 = 8'hFF; d4 = 1'b1;
`ifdef D_FLOP_CE_EN
    ce = 1'b1;
`endif
    #1;
    chk_u1("rst0", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("rst0.q3", {24'd0, q3}, 32'h0);

    // Reset holds everything while d toggles.
    for (int i = 0; i < 3; i++) begin
      d1 = ~d1; d3 = ~d3; d4 = ~d4;
      tick();
      chk_u1("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 0);
      chk("rst_hold.q3", {24'd0, q3}, 32'h0);
      chk("rst_hold.q4", {31'd0, q4}, 32'h0);
    end
    #1;
    rst = 1'b0; d1 = 1'b0; d3 = 8'h00; d4 = 1'b0;

    // Basic capture and edge flags.
    for (int i = 0; i < 9; i++) begin
      d1 = tbl[i].d;
      tick();
      chk_u1($sformatf("vec%0d", i), tbl[i].q, tbl[i].rise, tbl[i].fall, tbl[i].chg, tbl[i].cnt);
      #1;
      d1 = ~d1;
      #2;
      chk($sformatf("vec%0d.stable", i), {31'd0, q1}, {31'd0, tbl[i].q});
    end

    // Async reset mid-stream, then capture on the first edge after release.
    d1 = 1'b1;
    tick();
    chk_u1("pre_rst", 1'b1, 1'b0, 1'b0, 1'b0, 7);
    #1;
    rst = 1'b1;
    #1;
    chk_u1("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_u1("rst_held", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end
    #1;
    rst = 1'b0;
    tick();
    chk_u1("release", 1'b1, 1'b1, 1'b0, 1'b1, 1);

    // Three-stage latency.
    #1;
    d3 = 8'hA5;
    tick();
    chk("lat0.q", {24'd0, q3}, {24'd0, lat_q[0]});
    chk("lat0.cnt", {16'd0, n3}, lat_cnt[0]);
    #1;
    d3 = 8'h00;
    for (int e = 1; e < 5; e++) begin
      tick();
      chk($sformatf("lat%0d.q", e), {24'd0, q3}, {24'd0, lat_q[e]});
      chk($sformatf("lat%0d.chg", e), {31'd0, c3}, {31'd0, lat_chg[e]});
      chk($sformatf("lat%0d.cnt", e), {16'd0, n3}, lat_cnt[e]);
    end

    // Counter wrap on the 4-bit instance.
    for (int k = 1; k <= 17; k++) begin
      #1;
      d4 = k[0];
      tick();
      chk($sformatf("wrap%0d.q", k), {31'd0, q4}, {31'd0, k[0]});
      chk($sformatf("wrap%0d.cnt", k), {28'd0, n4}, k % 16);
    end

`ifdef D_FLOP_CE_EN
    // Clock enable low freezes state and suppresses flags.
    #1;
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d4 = i[0];
      tick();
      chk("ce_off.q", {31'd0, q4}, 32'd1);
      chk("ce_off.cnt", {28'd0, n4}, 32'd1);
      chk("ce_off.flags", {29'd0, r4, f4, c4}, 32'd0);
      #1;
    end
    ce = 1'b1;
    d4 = 1'b0;
    tick();
    chk("ce_on.q", {31'd0, q4}, 32'd0);
    chk("ce_on.fall", {31'd0, f4}, 32'd1);
    chk("ce_on.cnt", {28'd0, n4}, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
